// File: rtl/serial_subtractor8.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per clock.
// start/busy/done handshake; diff/bout are registered and held until the next completion.
module serial_subtractor8 #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic d, brw_n, last;

  always_comb begin
    d     = a_sh[0] ^ b_sh[0] ^ brw;
    brw_n = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & brw) | (b_sh[0] & brw);
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // busy/done are registered from the next state so the outputs come straight off flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            brw    <= bin;
            cnt    <= '0;
            res_sh <= '0;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= {d, res_sh[WIDTH-1:1]};
          brw    <= brw_n;
          cnt    <= cnt + 1'b1;
          if (last) begin
            diff <= {d, res_sh[WIDTH-1:1]};
            bout <= brw_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor8.sv
// Directed-vector bench for serial_subtractor8 with hand-computed expected results.
module tb_serial_subtractor8;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             bin;
  logic             busy, done, bout;
  logic [WIDTH-1:0] diff;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  serial_subtractor8 #(.WIDTH(WIDTH), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bounded wait for the done pulse; n = negedges waited, or the bound on timeout.
  task automatic wait_done(output int unsigned n);
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One full operation: checks busy length, latency, single-cycle done, hold of old result,
  // operand capture (inputs scrambled after acceptance) and ignored start while busy.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin, input logic [7:0] ed, input logic eb);
    logic [7:0]  prev_d;
    logic        prev_b, held_bad;
    int unsigned nbusy, cyc;
    prev_d = diff; prev_b = bout; held_bad = 1'b0; nbusy = 0;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb; bin = ~tbin;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (done) break;
      if (busy) nbusy++;
      if (diff !== prev_d || bout !== prev_b) held_bad = 1'b1;
      start = (cyc == 2);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy"}, nbusy, WIDTH);
    check({tag, "_lat"}, cyc, WIDTH);
    check({tag, "_done"}, done, 1);
    check({tag, "_held"}, held_bad, 0);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, eb);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int unsigned n, dones;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    rst = 1'b0;

    do_op("v50_20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0);
    do_op("v20_50", 8'h20, 8'h50, 1'b0, 8'hD0, 1'b1);
    do_op("v00_00", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    do_op("vFF_FF", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    do_op("vFF_00", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
    do_op("v80_7F", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    do_op("v00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    do_op("vA5_5A", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0);

    // Back-to-back with start held high; a changes mid-RUN of the first op.
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    repeat (4) @(negedge clk);
    a = 8'h80;
    wait_done(n);
    check("b2b_first_done", done, 1);
    check("b2b_first_diff", diff, 8'h0F);
    check("b2b_first_bout", bout, 0);
    @(negedge clk);
    check("b2b_rerun_busy", busy, 1);
    wait_done(n);
    check("b2b_period", n + 1, WIDTH + 1);
    check("b2b_second_diff", diff, 8'h7F);
    check("b2b_second_bout", bout, 0);
    start = 1'b0;
    @(negedge clk);
    check("b2b_stop_busy", busy, 0);

    // Reset in the middle of a run: abandoned, outputs cleared, no done pulse.
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_bout", bout, 0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("mid_no_done", dones, 0);

    // Reset and start together: reset wins.
    rst = 1'b1; start = 1'b1; a = 8'h44; b = 8'h22;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    @(negedge clk);
    check("rst_start_stay", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_subtractor8.md
Name: serial_subtractor8

Overview:
- Bit-serial WIDTH-bit subtractor: computes diff = a - b - bin and borrow-out bout, LSB first, one bit per clock.
- Inverse-direction companion to the team's combinational adder datapath; used where area matters more than latency.
- Operands and borrow-in are captured on start; the result is registered and held until the next operation completes.
- Controlled by a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).
- CW, 4, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; diff/bout newly valid.
- diff  output  WIDTH  registered difference, (a - b - bin) mod 2^WIDTH.
- bout  output  1  registered borrow-out; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset (rst=1 at a clock edge, overrides everything):
  - state<=IDLE, busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and counter are cleared.
- States: IDLE, RUN, DONE.
  - busy=1 only in RUN.
  - done=1 only in DONE.
  - All outputs come directly from flops.
- IDLE, or DONE, with start=1:
  - Load a_sh<=a, b_sh<=b, brw<=bin, cnt<=0, res_sh<=0; go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - d = a_sh[0] ^ b_sh[0] ^ brw.
  - brw <= (~a_sh[0] & b_sh[0]) | (~a_sh[0] & brw) | (b_sh[0] & brw).
  - res_sh <= {d, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1.
  - cnt <= cnt + 1.
- RUN, cycle with cnt == WIDTH-1 (last bit):
  - diff <= {d, res_sh[WIDTH-1:1]}; bout <= next brw value.
  - Go to DONE.
- Latency:
  - Start accepted at edge k; busy high cycles k+1..k+WIDTH.
  - done high for exactly one cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from start.
- Throughput:
  - start asserted during the DONE cycle is accepted; back-to-back operations every WIDTH+1 cycles.
- start while busy=1 is ignored: no restart, no effect on operands or result.
- diff/bout hold the previous result throughout RUN; they change only on the transition into DONE.
- a/b/bin may change freely after acceptance; the captured values are used.
- Reset mid-RUN:
  - The operation is abandoned; no done pulse.
  - Outputs go to their reset values on that edge.
- rst and start in the same cycle: reset wins; start is dropped.
- No combinational path from inputs to outputs.

Test Plan:
- a=0x50, b=0x20, bin=0, start 1 cycle -> busy high 8 cycles, done pulse on cycle 9; diff=0x30, bout=0.
- a=0x20, b=0x50, bin=0 -> diff=0xD0, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
- Hold start=1 continuously with a=0x10, b=0x01: first result diff=0x0F.
  - Start re-accepted in each DONE cycle, so done pulses every 9 cycles.
  - Changing a to 0x80 mid-RUN does not affect the current result.
  - Next result is diff=0x7F.
- Assert rst at RUN cycle 4 of a=0x33, b=0x11 -> next cycle busy=0, done=0, diff=0x00, bout=0; no done pulse follows.
- Randomized (1000 ops, random idle gaps) against a reference model: diff == (a-b-bin) mod 256, bout == (a < b+bin), and diff held stable between done pulses.
